// File: rtl/fifo_stream_adapter_pkg.sv
// Shared types and constants for the FIFO-to-stream adapter.
// The optional TLAST feature is enabled with the STREAM_TLAST_EN macro.
package fifo_stream_pkg;

  // Buffer occupancy states; the encoding equals the number of buffered beats
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_state_t;

  localparam int unsigned C_BUF_DEPTH = 2;

  // Width of the TLAST beat counter for a given packet length
  function automatic int unsigned beat_cnt_width(input int unsigned pkt_len);
    return $clog2(pkt_len) + 1;
  endfunction

endpackage

// File: rtl/fifo_stream_adapter_if.sv
// Valid/ready stream bundle driven by fifo_stream_adapter.
// Signal names follow the adapter's point of view (o_ = driven by adapter).
// o_tlast exists only when STREAM_TLAST_EN is defined.
interface fifo_stream_adapter_if #(
  parameter int unsigned G_WIDTH = 8
);
  logic               o_tvalid;
  logic [G_WIDTH-1:0] o_tdata;
  logic               i_tready;
`ifdef STREAM_TLAST_EN
  logic               o_tlast;

  modport master (output o_tvalid, output o_tdata, output o_tlast, input i_tready);
  modport slave  (input  o_tvalid, input  o_tdata, input  o_tlast, output i_tready);
`else
  modport master (output o_tvalid, output o_tdata, input i_tready);
  modport slave  (input  o_tvalid, input  o_tdata, output i_tready);
`endif
endinterface

// File: rtl/fifo_stream_adapter_skid_buf.sv
// Two-entry register buffer (head/tail) with push, pop and occupancy count.
// A push arriving with no free slot (after any same-cycle pop) is dropped
// and flagged on o_ovf.
module stream_skid_buf
  import fifo_stream_pkg::*;
#(
  parameter int unsigned G_WIDTH = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic [G_WIDTH-1:0] i_data,
  input  logic               i_pop,
  output logic               o_valid,
  output logic [G_WIDTH-1:0] o_head,
  output logic [1:0]         o_count,
  output logic               o_ovf
);

  buf_state_t         r_state;
  logic [G_WIDTH-1:0] r_head;
  logic [G_WIDTH-1:0] r_tail;

  // Occupancy FSM; pushed data lands in the first slot free after the pop
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= EMPTY;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (i_push) begin
            r_head  <= i_data;
            r_state <= ONE;
          end
        end
        ONE: begin
          case ({i_pop, i_push})
            2'b11: r_head <= i_data;
            2'b10: r_state <= EMPTY;
            2'b01: begin
              r_tail  <= i_data;
              r_state <= TWO;
            end
            default: ;
          endcase
        end
        TWO: begin
          if (i_pop) begin
            r_head <= r_tail;
            if (i_push) r_tail  <= i_data;
            else        r_state <= ONE;
          end
        end
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign o_valid = (r_state != EMPTY);
  assign o_head  = r_head;
  assign o_count = r_state;
  assign o_ovf   = i_push & (r_state == TWO) & ~i_pop;

endmodule

// File: rtl/fifo_stream_adapter.sv
// Read-side consumer for synchronous_fifo: issues FIFO reads against buffer
// credit, captures returned words and presents them as a valid/ready stream.
// Optional macro STREAM_TLAST_EN adds a per-packet o_tlast (G_PKT_LEN beats).
module fifo_stream_adapter
  import fifo_stream_pkg::*;
#(
  parameter int unsigned G_WIDTH   = 8,
  parameter int unsigned G_PKT_LEN = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_fifo_empty,
  input  logic [G_WIDTH-1:0]    i_fifo_data,
  input  logic                  i_fifo_rd_done,
  output logic                  o_fifo_rd,
  fifo_stream_adapter_if.master m_stream,
  output logic [1:0]            o_level,
  output logic                  o_err
);

  localparam logic [2:0] C_DEPTH = 3'(C_BUF_DEPTH);

  if (G_PKT_LEN < 1) begin : g_bad_pkt_len
    $error("fifo_stream_adapter: G_PKT_LEN must be >= 1");
  end

  logic               w_valid;
  logic [G_WIDTH-1:0] w_head;
  logic [1:0]         w_count;
  logic               w_ovf;
  logic               w_pop;
  logic               w_capture;
  logic [2:0]         w_credit;
  logic               r_inflight;
  logic               r_err;

  assign w_pop     = w_valid & m_stream.i_tready;
  assign w_capture = i_fifo_rd_done & r_inflight;

  // Slots committed after this cycle's pop; the tready->rd path keeps 1 beat/cycle
  assign w_credit  = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign o_fifo_rd = ~i_rst & ~i_fifo_empty & (w_credit < C_DEPTH);

  stream_skid_buf #(
    .G_WIDTH (G_WIDTH)
  ) u_buf (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_capture),
    .i_data  (i_fifo_data),
    .i_pop   (w_pop),
    .o_valid (w_valid),
    .o_head  (w_head),
    .o_count (w_count),
    .o_ovf   (w_ovf)
  );

  // Outstanding-read tracker; a new read in the capture cycle keeps it set
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          r_inflight <= 1'b0;
    else if (o_fifo_rd) r_inflight <= 1'b1;
    else if (w_capture) r_inflight <= 1'b0;
  end

  // Sticky error: unsolicited read data or a capture with no free slot
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                                      r_err <= 1'b0;
    else if ((i_fifo_rd_done & ~r_inflight) | w_ovf) r_err <= 1'b1;
  end

  assign m_stream.o_tvalid = w_valid;
  assign m_stream.o_tdata  = w_head;
  assign o_level           = w_count;
  assign o_err             = r_err;

`ifdef STREAM_TLAST_EN
  localparam int unsigned          C_CNT_W     = beat_cnt_width(G_PKT_LEN);
  localparam logic [C_CNT_W-1:0]   C_LAST_BEAT = C_CNT_W'(G_PKT_LEN - 1);

  logic [C_CNT_W-1:0] r_beat_cnt;

  // Beat position within the packet, wrapping on the pop of the last beat
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_beat_cnt <= '0;
    end else if (w_pop) begin
      r_beat_cnt <= (r_beat_cnt == C_LAST_BEAT) ? '0 : r_beat_cnt + 1'b1;
    end
  end

  assign m_stream.o_tlast = w_valid & (r_beat_cnt == C_LAST_BEAT);
`endif

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// Self-checking bench for fifo_stream_adapter: a queue-based FIFO with
// one-cycle read latency feeds the DUT; a scoreboard of written words and a
// beat-accounting model supply all expected values.
// Compile with +define+STREAM_TLAST_EN to also check o_tlast.
module tb_fifo_stream_adapter;

  localparam int unsigned W   = 8;
  localparam int unsigned PKT = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_empty = 1'b1;
  logic         fifo_rd_done = 1'b0;
  logic [W-1:0] fifo_data = '0;
  logic         fifo_rd;
  logic [1:0]   level;
  logic         err;

  fifo_stream_adapter_if #(.G_WIDTH(W)) s_if ();

  fifo_stream_adapter #(
    .G_WIDTH   (W),
    .G_PKT_LEN (PKT)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_fifo_empty   (fifo_empty),
    .i_fifo_data    (fifo_data),
    .i_fifo_rd_done (fifo_rd_done),
    .o_fifo_rd      (fifo_rd),
    .m_stream       (s_if),
    .o_level        (level),
    .o_err          (err)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  int           lvl = 0;
  logic         err_exp = 1'b0;
  logic         inject = 1'b0;
  int           beats = 0;
  int           mask_base = 0;
  logic [7:0]   tlast_mask = '0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;
  logic [W-1:0] last_beat = '0;
  int           cyc_n = 0;
  int           n_reads = 0;
  int           first_rd_cyc = -1;
  int           first_valid_cyc = -1;
  int           first_pop_cyc = -1;
  int           last_pop_cyc = -1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic clear_marks();
    n_reads = 0;
    first_rd_cyc = -1;
    first_valid_cyc = -1;
    first_pop_cyc = -1;
    last_pop_cyc = -1;
  endtask

  // One clock: drive at posedge+1, check at negedge, advance the FIFO model.
  task automatic cycle(input logic ready);
    logic         exp_pop;
    logic         exp_rd;
    logic         rd_seen;
    logic [W-1:0] exp_word;
    int           incoming;
    s_if.i_tready = ready;
    fifo_empty    = (fifo_q.size() == 0);
    @(negedge clk);
    incoming = (fifo_rd_done && !inject) ? 1 : 0;
    exp_pop  = (lvl != 0) && ready;
    exp_rd   = !fifo_empty && ((lvl + incoming - (exp_pop ? 1 : 0)) < 2);
    check("fifo_rd", fifo_rd, exp_rd);
    check("tvalid", s_if.o_tvalid, lvl != 0);
    check("level", level, lvl);
    check("err", err, err_exp);
    if (prev_stall) check("hold_tdata", s_if.o_tdata, prev_data);
`ifdef STREAM_TLAST_EN
    if (!s_if.o_tvalid) check("tlast_idle", s_if.o_tlast, 0);
`endif
    if (fifo_rd) begin
      n_reads++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc_n;
    end
    if (s_if.o_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc_n;
    if (s_if.o_tvalid && ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", s_if.o_tvalid, 0);
      end else begin
        exp_word = exp_q.pop_front();
        check("tdata", s_if.o_tdata, exp_word);
      end
`ifdef STREAM_TLAST_EN
      check("tlast", s_if.o_tlast, (beats % PKT) == (PKT - 1));
      if (beats >= mask_base && beats - mask_base < 8)
        tlast_mask[beats - mask_base] = s_if.o_tlast;
`endif
      beats++;
      last_beat = s_if.o_tdata;
      if (first_pop_cyc < 0) first_pop_cyc = cyc_n;
      last_pop_cyc = cyc_n;
    end
    prev_stall = s_if.o_tvalid && !ready;
    prev_data  = s_if.o_tdata;
    rd_seen    = fifo_rd && (fifo_q.size() != 0);
    @(posedge clk);
    #1;
    lvl          = lvl + incoming - (exp_pop ? 1 : 0);
    inject       = 1'b0;
    fifo_rd_done = rd_seen;
    if (rd_seen) fifo_data = fifo_q.pop_front();
    cyc_n++;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || lvl != 0) && n < budget) begin
      cycle(1'b1);
      n++;
    end
    check(tag, exp_q.size() + lvl, 0);
  endtask

  // Asynchronous reset away from the clock edge; the FIFO model is reset too.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_tvalid", s_if.o_tvalid, 0);
    check("rst_level", level, 0);
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_err", err, 0);
    fifo_q.delete();
    exp_q.delete();
    lvl = 0;
    err_exp = 1'b0;
    inject = 1'b0;
    beats = 0;
    prev_stall = 1'b0;
    fifo_rd_done = 1'b0;
    fifo_empty = 1'b1;
    s_if.i_tready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] first_word;
    int           n;
    s_if.i_tready = 1'b0;
    #1;
    do_reset();

    // Test 1: idle with an empty FIFO
    repeat (10) cycle(1'($urandom_range(0, 1)));

    // Test 2: three words, latency and back-to-back beats
    clear_marks();
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    drain("t2_drain", 20);
    check("t2_latency", first_valid_cyc - first_rd_cyc, 2);
    check("t2_b2b", last_pop_cyc - first_pop_cyc, 2);

    // Test 3: 16 words with consumer stalled, then released
    clear_marks();
    for (int i = 0; i < 16; i++) push_word(W'($urandom));
    first_word = exp_q[0];
    repeat (6) cycle(1'b0);
    check("t3_reads", n_reads, 2);
    check("t3_level", level, 2);
    check("t3_head", s_if.o_tdata, first_word);
    first_pop_cyc = -1;
    drain("t3_drain", 40);
    check("t3_b2b", last_pop_cyc - first_pop_cyc, 15);

    // Test 4: alternating ready over 20 words
    for (int i = 0; i < 20; i++) push_word(W'($urandom));
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cycle(1'(n % 2 == 0));
      n++;
    end
    check("t4_drain", exp_q.size(), 0);
    drain("t4_settle", 10);

    // Random traffic: bursty writes, random backpressure
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 1) == 1 && fifo_q.size() < 16) push_word(W'($urandom));
      cycle(1'($urandom_range(0, 3) != 0));
    end
    drain("rand_drain", 60);

    // Test 5: reset mid-burst, then a fresh word
    for (int i = 0; i < 10; i++) push_word(W'($urandom));
    repeat (5) cycle(1'b0);
    check("t5_level_pre", level, 2);
    do_reset();
    push_word(8'hA5);
    drain("t5_drain", 10);
    check("t5_first", last_beat, 8'hA5);
    check("t5_beats", beats, 1);

`ifdef STREAM_TLAST_EN
    // Test 6: TLAST on beats 4 and 8 of an 8-word stream after reset
    do_reset();
    mask_base = 0;
    tlast_mask = '0;
    for (int i = 0; i < 8; i++) push_word(W'($urandom));
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      cycle(1'($urandom_range(0, 2) != 0));
      n++;
    end
    drain("t6_drain", 10);
    check("t6_tlast_mask", tlast_mask, 8'b1000_1000);
`endif

    // Unsolicited read data: dropped, sticky error
    drain("err_idle", 10);
    inject = 1'b1;
    fifo_rd_done = 1'b1;
    fifo_data = 8'hEE;
    cycle(1'b1);
    err_exp = 1'b1;
    repeat (6) cycle(1'($urandom_range(0, 1)));
    check("err_sticky", err, 1);
    push_word(8'h5A);
    drain("err_after", 10);
    check("err_after_data", last_beat, 8'h5A);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

endmodule
